mips_lsu_avalon_master: RTL and testbench

CPU-side load/store master. Converts one MIPS data access (LB/LBU/LH/LHU/LW/SB/SH/SW) into a single word-aligned Avalon-MM transaction to the memory slave. It holds the transaction stable through waitrequest and returns the extended load result to the pipeline. It sits between the CPU memory stage and the Avalon data port.

---
 rtl/mips_lsu_pkg.sv | 29 ++
 rtl/mips_lsu_avalon_master_lane.sv | 52 +++++
 rtl/mips_lsu_avalon_master.sv | 152 +++++++++++++++
 tb/tb_mips_lsu_avalon_master.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types for the MIPS load/store Avalon master: access sizes, FSM states
// and the alignment rule used to reject a request before it reaches the bus.
package mips_lsu_pkg;

    typedef enum logic [1:0] {
        SzByte = 2'd0,
        SzHalf = 2'd1,
        SzWord = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StErr  = 2'd2
    } state_e;

    // Size 3 is not a legal access and is reported like a misaligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SzByte:  mis = 1'b0;
            SzHalf:  mis = off[0];
            SzWord:  mis = (off != 2'b00);
            default: mis = 1'b1;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mips_lsu_avalon_master_lane.sv
// Little-endian lane steering: store byteenable/writedata generation and
// load extraction with zero or sign extension.
module mips_lsu_avalon_master_lane
    import mips_lsu_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wdata_i,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic        ld_signed_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_ext_o
);

    logic [31:0] ld_shifted;

    always_comb begin
        st_be_o    = 4'b1111;
        st_wdata_o = st_wdata_i;
        case (st_size_i)
            SzByte: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wdata_i[7:0]}};
            end
            SzHalf: begin
                st_be_o    = 4'b0011 << st_off_i;
                st_wdata_o = {2{st_wdata_i[15:0]}};
            end
            default: begin
                st_be_o    = 4'b1111;
                st_wdata_o = st_wdata_i;
            end
        endcase
    end

    assign ld_shifted = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_ext_o = ld_shifted;
        case (ld_size_i)
            SzByte: ld_ext_o = ld_signed_i ? {{24{ld_shifted[7]}}, ld_shifted[7:0]}
                                           : {24'h0, ld_shifted[7:0]};
            SzHalf: ld_ext_o = ld_signed_i ? {{16{ld_shifted[15]}}, ld_shifted[15:0]}
                                           : {16'h0, ld_shifted[15:0]};
            default: ld_ext_o = ld_shifted;
        endcase
    end

endmodule

// File: rtl/mips_lsu_avalon_master.sv
// Turns one CPU load/store into a single word-aligned Avalon-MM transaction,
// holding it through waitrequest and returning the extended load result.
module mips_lsu_avalon_master
    import mips_lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata
);

    state_e      state_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] cnt_q;
    logic        read_q;
    logic        write_q;
    logic [31:0] address_q;
    logic [31:0] writedata_q;
    logic [3:0]  byteenable_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_rdata_q;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] ld_ext;
    logic [31:0] cnt_inc;
    logic        timeout_hit;
    logic        req_mis;

    mips_lsu_avalon_master_lane u_lane (
        .st_size_i   (req_size),
        .st_off_i    (req_addr[1:0]),
        .st_wdata_i  (req_wdata),
        .st_be_o     (lane_be),
        .st_wdata_o  (lane_wdata),
        .ld_size_i   (size_q),
        .ld_off_i    (off_q),
        .ld_signed_i (signed_q),
        .ld_rdata_i  (readdata),
        .ld_ext_o    (ld_ext)
    );

    assign req_mis     = is_misaligned(req_size, req_addr[1:0]);
    assign cnt_inc     = cnt_q + 32'd1;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            wr_q         <= 1'b0;
            size_q       <= 2'b00;
            signed_q     <= 1'b0;
            off_q        <= 2'b00;
            cnt_q        <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= 32'd0;
            writedata_q  <= 32'd0;
            byteenable_q <= 4'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        wr_q         <= req_write;
                        size_q       <= req_size;
                        signed_q     <= req_signed;
                        off_q        <= req_addr[1:0];
                        cnt_q        <= 32'd0;
                        resp_rdata_q <= 32'd0;
                        if (req_mis) begin
                            // Rejected without touching the bus; response goes out next cycle.
                            state_q      <= StErr;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state_q      <= StBus;
                            address_q    <= {req_addr[31:2], 2'b00};
                            writedata_q  <= lane_wdata;
                            byteenable_q <= lane_be;
                            read_q       <= ~req_write;
                            write_q      <= req_write;
                        end
                    end
                end
                StBus: begin
                    if (!waitrequest) begin
                        read_q       <= 1'b0;
                        write_q      <= 1'b0;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= wr_q ? 32'd0 : ld_ext;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_inc;
                        if (timeout_hit) begin
                            read_q       <= 1'b0;
                            write_q      <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                            state_q      <= StIdle;
                        end
                    end
                end
                StErr: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign writedata  = writedata_q;
    assign byteenable = byteenable_q;

endmodule

// File: tb/tb_mips_lsu_avalon_master.sv
// Directed bench for mips_lsu_avalon_master against a small Avalon memory slave
// with programmable wait states and a stuck-waitrequest mode.
module tb_mips_lsu_avalon_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    int total = 0;
    int bad   = 0;

    // Slave model state
    logic [31:0] mem [16];
    int          wait_n = 0;
    int          wcnt;
    logic        stuck = 1'b0;
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = 4'd0;
    logic [31:0] pl_val = 32'd0;

    // Observations from the last run_req
    int          lat;
    int          bus_cycles;
    logic        both_hi;
    logic        s_rdy;
    logic        s_read;
    logic        s_write;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wdata;

    always #5 clk = ~clk;

    mips_lsu_avalon_master #(
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_size    (req_size),
        .req_signed  (req_signed),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .waitrequest (waitrequest),
        .readdata    (readdata)
    );

    assign waitrequest = (read || write) && (stuck || (wcnt < wait_n));
    assign readdata    = mem[address[5:2]];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            wcnt <= 0;
        end else begin
            if (read || write) begin
                if (waitrequest) begin
                    wcnt <= wcnt + 1;
                end else begin
                    wcnt <= 0;
                    if (write) begin
                        for (int k = 0; k < 4; k++) begin
                            if (byteenable[k]) mem[address[5:2]][8*k +: 8] <= writedata[8*k +: 8];
                        end
                    end
                end
            end else begin
                wcnt <= 0;
            end
            if (pl_en) mem[pl_idx] <= pl_val;
        end
    end

    task automatic preload(input logic [3:0] idx, input logic [31:0] val);
        pl_idx = idx;
        pl_val = val;
        pl_en  = 1'b1;
        @(negedge clk);
        pl_en  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where resp_valid is seen (or budget runs out).
    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd);
        s_rdy      = req_ready;
        req_valid  = 1'b1;
        req_write  = wr;
        req_size   = sz;
        req_signed = sg;
        req_addr   = a;
        req_wdata  = wd;
        @(negedge clk);
        req_valid  = 1'b0;
        req_addr   = 32'hFFFF_FFFF;
        req_wdata  = 32'h5A5A_5A5A;
        s_read     = read;
        s_write    = write;
        s_addr     = address;
        s_be       = byteenable;
        s_wdata    = writedata;
        lat        = 1;
        bus_cycles = (read || write) ? 1 : 0;
        both_hi    = read && write;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
            if (read || write) bus_cycles++;
            if (read && write) both_hi = 1'b1;
        end
    endtask

    task automatic test_reset;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", req_ready); end
        total++; if ({read, write} !== 2'b00) begin bad++; $display("FAIL reset_rw got=%b want=00", {read, write}); end
        total++; if (address !== 32'd0) begin bad++; $display("FAIL reset_addr got=%h want=0", address); end
        total++; if (writedata !== 32'd0 || byteenable !== 4'd0) begin
            bad++; $display("FAIL reset_wd_be got=%h/%b want=0/0000", writedata, byteenable); end
        total++; if ({resp_valid, resp_err} !== 2'b00 || resp_rdata !== 32'd0) begin
            bad++; $display("FAIL reset_resp got=%b%b/%h want=00/0", resp_valid, resp_err, resp_rdata); end
    endtask

    task automatic test_lw_waits;
        preload(4'd4, 32'hDEAD_BEEF);
        wait_n = 2;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0);
        total++; if (s_read !== 1'b1 || s_write !== 1'b0) begin
            bad++; $display("FAIL lw_rw got=%b%b want=10", s_read, s_write); end
        total++; if (s_addr !== 32'h10 || s_be !== 4'b1111) begin
            bad++; $display("FAIL lw_addr_be got=%h/%b want=10/1111", s_addr, s_be); end
        total++; if (bus_cycles !== 3 || lat !== 4) begin
            bad++; $display("FAIL lw_timing got=bus%0d/lat%0d want=bus3/lat4", bus_cycles, lat); end
        total++; if (resp_rdata !== 32'hDEAD_BEEF || resp_err !== 1'b0) begin
            bad++; $display("FAIL lw_data got=%h/%b want=deadbeef/0", resp_rdata, resp_err); end
        total++; if (read !== 1'b0) begin bad++; $display("FAIL lw_read_drop got=%b want=0", read); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL lw_pulse got=%b want=0", resp_valid); end
        wait_n = 0;
    endtask

    task automatic test_lb;
        preload(4'd4, 32'h80FF_0102);
        run_req(1'b0, 2'd0, 1'b1, 32'h0000_0013, 32'd0);
        total++; if (s_be !== 4'b1000 || s_addr !== 32'h10) begin
            bad++; $display("FAIL lb_be got=%b/%h want=1000/10", s_be, s_addr); end
        total++; if (lat !== 2) begin bad++; $display("FAIL lb_latency got=%0d want=2", lat); end
        total++; if (resp_rdata !== 32'hFFFF_FF80) begin
            bad++; $display("FAIL lb_signed got=%h want=ffffff80", resp_rdata); end
        @(negedge clk);
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0013, 32'd0);
        total++; if (resp_rdata !== 32'h0000_0080) begin
            bad++; $display("FAIL lbu_unsigned got=%h want=00000080", resp_rdata); end
        @(negedge clk);
        run_req(1'b0, 2'd1, 1'b1, 32'h0000_0010, 32'd0);
        total++; if (resp_rdata !== 32'h0000_0102 || s_be !== 4'b0011) begin
            bad++; $display("FAIL lh_low got=%h/%b want=00000102/0011", resp_rdata, s_be); end
        @(negedge clk);
        run_req(1'b0, 2'd1, 1'b1, 32'h0000_0012, 32'd0);
        total++; if (resp_rdata !== 32'hFFFF_80FF) begin
            bad++; $display("FAIL lh_signed_hi got=%h want=ffff80ff", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_sh;
        preload(4'd8, 32'h1122_3344);
        run_req(1'b1, 2'd1, 1'b0, 32'h0000_0022, 32'h0000_ABCD);
        total++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_addr !== 32'h20) begin
            bad++; $display("FAIL sh_cmd got=w%b r%b %h want=w1 r0 20", s_write, s_read, s_addr); end
        total++; if (s_be !== 4'b1100 || s_wdata !== 32'hABCD_ABCD) begin
            bad++; $display("FAIL sh_lanes got=%b/%h want=1100/abcdabcd", s_be, s_wdata); end
        total++; if (resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            bad++; $display("FAIL sh_resp got=%h/%b want=0/0", resp_rdata, resp_err); end
        @(negedge clk);
        run_req(1'b1, 2'd0, 1'b0, 32'h0000_0021, 32'h0000_0077);
        total++; if (s_be !== 4'b0010 || s_wdata !== 32'h7777_7777) begin
            bad++; $display("FAIL sb_lanes got=%b/%h want=0010/77777777", s_be, s_wdata); end
        @(negedge clk);
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0);
        total++; if (resp_rdata !== 32'hABCD_7744) begin
            bad++; $display("FAIL sh_readback got=%h want=abcd7744", resp_rdata); end
        @(negedge clk);
    endtask

    task automatic test_misaligned;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0);
        total++; if (lat !== 1 || resp_err !== 1'b1 || resp_rdata !== 32'd0) begin
            bad++; $display("FAIL mis_lw got=lat%0d err%b %h want=lat1 err1 0", lat, resp_err, resp_rdata); end
        total++; if (bus_cycles !== 0 || req_ready !== 1'b0) begin
            bad++; $display("FAIL mis_lw_bus got=bus%0d rdy%b want=bus0 rdy0", bus_cycles, req_ready); end
        @(negedge clk);
        total++; if (resp_valid !== 1'b0 || req_ready !== 1'b1 || {read, write} !== 2'b00) begin
            bad++; $display("FAIL mis_recover got=v%b rdy%b rw%b%b want=v0 rdy1 rw00",
                            resp_valid, req_ready, read, write); end
        run_req(1'b1, 2'd1, 1'b0, 32'h0000_0021, 32'h1234);
        total++; if (resp_err !== 1'b1 || bus_cycles !== 0) begin
            bad++; $display("FAIL mis_sh got=err%b bus%0d want=err1 bus0", resp_err, bus_cycles); end
        @(negedge clk);
        run_req(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0);
        total++; if (resp_err !== 1'b1 || bus_cycles !== 0) begin
            bad++; $display("FAIL mis_size3 got=err%b bus%0d want=err1 bus0", resp_err, bus_cycles); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        stuck = 1'b1;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0000, 32'd0);
        total++; if (bus_cycles !== 4 || lat !== 5) begin
            bad++; $display("FAIL timeout_timing got=bus%0d/lat%0d want=bus4/lat5", bus_cycles, lat); end
        total++; if (resp_err !== 1'b1 || resp_rdata !== 32'd0 || read !== 1'b0) begin
            bad++; $display("FAIL timeout_resp got=err%b %h rd%b want=err1 0 rd0", resp_err, resp_rdata, read); end
        stuck = 1'b0;
        run_req(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0);
        total++; if (s_rdy !== 1'b1 || s_read !== 1'b1) begin
            bad++; $display("FAIL b2b_accept got=rdy%b rd%b want=rdy1 rd1", s_rdy, s_read); end
        total++; if (lat !== 2 || resp_rdata !== 32'h80FF_0102 || resp_err !== 1'b0) begin
            bad++; $display("FAIL b2b_data got=lat%0d %h err%b want=lat2 80ff0102 err0",
                            lat, resp_rdata, resp_err); end
        total++; if (both_hi !== 1'b0) begin bad++; $display("FAIL rw_exclusive got=%b want=0", both_hi); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_bus;
        stuck     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_size  = 2'd2;
        req_addr  = 32'h0000_0010;
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (read !== 1'b1) begin bad++; $display("FAIL rst_pre_read got=%b want=1", read); end
        #1 reset = 1'b1;
        #1;
        total++; if ({read, write, resp_valid} !== 3'b000 || clk !== 1'b0) begin
            bad++; $display("FAIL rst_async got=rw%b%b v%b clk%b want=000 clk0", read, write, resp_valid, clk); end
        stuck = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        total++; if (req_ready !== 1'b1 || read !== 1'b0) begin
            bad++; $display("FAIL rst_post got=rdy%b rd%b want=rdy1 rd0", req_ready, read); end
        run_req(1'b0, 2'd0, 1'b0, 32'h0000_0010, 32'd0);
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL rst_lb_resp got=%b want=1", resp_valid); end
        #1 reset = 1'b1;
        #1;
        total++; if (resp_valid !== 1'b0 || clk !== 1'b0) begin
            bad++; $display("FAIL rst_resp_async got=%b want=0", resp_valid); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_size   = 2'd0;
        req_signed = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_lw_waits();
        test_lb();
        test_sh();
        test_misaligned();
        test_back_to_back();
        test_reset_mid_bus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
        $fatal(1, "bench did not finish");
    end

endmodule
